// File: rtl/riscv_mc_controller.sv
// ---------------------------------------------------------------------------
// riscv_mc_controller
//
// Main control unit of the multicycle RV32I core. It decodes the instruction
// register fields and steps the shared datapath (one ALU, one unified
// instruction/data memory) through several cycles per instruction.
// Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
//
// Parameters
//   MEM_WAIT_CYCLES  extra wait cycles per memory access (FETCH, MEMREAD,
//                    MEMWRITE each last MEM_WAIT_CYCLES+1 cycles)
//   STATE_W          width of the state_o debug port (>= 4)
//
// Build option
//   RISCV_MC_TRAP_EN  when defined, an unknown opcode sends the FSM to TRAP,
//                     which holds with every enable low until reset, and the
//                     sticky illegal_op flag is set. When undefined, an
//                     unknown opcode is skipped as a 2-cycle nop and
//                     illegal_op is tied low.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   op           in   instr[6:0]
//   funct3       in   instr[14:12]
//   funct7b5     in   instr[30]
//   zero         in   ALU zero flag
//   pc_write     out  PC enable = pc_update | (branch & zero)
//   adr_src      out  memory address select: 0 = PC, 1 = result
//   mem_write    out  memory write enable
//   ir_write     out  instruction register / OldPC enable
//   reg_write    out  register file write enable
//   result_src   out  00 ALUOut, 01 mem data, 10 ALU result
//   alu_src_a    out  00 PC, 01 OldPC, 10 RD1
//   alu_src_b    out  00 RD2, 01 ImmExt, 10 const 4
//   alu_control  out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src      out  00 I, 01 S, 10 B, 11 J
//   illegal_op   out  sticky illegal-opcode flag
//   state_o      out  current state encoding (debug)
// ---------------------------------------------------------------------------
module riscv_mc_controller #(
    parameter int MEM_WAIT_CYCLES = 0,
    parameter int STATE_W         = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic       w_last;       // final cycle of a (possibly stretched) memory state
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic [1:0] w_aluop;

    // -----------------------------------------------------------------------
    // Memory wait counter. Counts within FETCH/MEMREAD/MEMWRITE and returns
    // to zero on the cycle the state is left, so every memory state starts
    // from a clean count.
    // -----------------------------------------------------------------------
    generate
        if (MEM_WAIT_CYCLES > 0) begin : g_wait
            localparam int CW = $clog2(MEM_WAIT_CYCLES + 1);
            logic [CW-1:0] r_wait_cnt;
            logic          w_wait_state;

            assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                                  (r_state == S_MEMWRITE);
            assign w_last       = (r_wait_cnt == CW'(MEM_WAIT_CYCLES));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_wait_cnt <= '0;
                end else if (w_wait_state && !w_last) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end else begin
                    r_wait_cnt <= '0;
                end
            end
        end else begin : g_no_wait
            assign w_last = 1'b1;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_last) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011,
                    7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = S_EXECR;
                    7'b0010011: w_next = S_EXECI;
                    7'b1100011: w_next = S_BEQ;
                    7'b1101111: w_next = S_JAL;
`ifdef RISCV_MC_TRAP_EN
                    default:    w_next = S_TRAP;
`else
                    default:    w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_last) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_last) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
`ifdef RISCV_MC_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`else
            S_TRAP:     w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore outputs (state-decoded). Enables are collected in w_ signals and
    // gated with reset below.
    // -----------------------------------------------------------------------
    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_aluop     = ALUOP_ADD;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        case (r_state)
            S_FETCH: begin
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_ir_write  = w_last;
                w_pc_update = w_last;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = w_last;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                w_aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
            end
            default: begin
                // TRAP and unused encodings drive nothing.
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU decoder. Subtraction on funct3=000 only for R-type (op[5]=1);
    // for I-type funct7b5 is part of the immediate.
    // -----------------------------------------------------------------------
    always_comb begin
        alu_control = 3'b000;
        case (w_aluop)
            ALUOP_SUB:   alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default:     alu_control = 3'b000;
        endcase
    end

    // Immediate format select, straight from the opcode.
    always_comb begin
        case (op)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    // Enables are held low for the whole time reset is asserted, so an
    // aborted instruction cannot leave a partial write behind.
    assign pc_write  = (w_pc_update | (w_branch & zero)) & reset;
    assign ir_write  = w_ir_write  & reset;
    assign reg_write = w_reg_write & reset;
    assign mem_write = w_mem_write & reset;

    assign state_o   = STATE_W'(r_state);

    // -----------------------------------------------------------------------
    // Sticky illegal-opcode flag
    // -----------------------------------------------------------------------
`ifdef RISCV_MC_TRAP_EN
    logic r_illegal_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_illegal_op <= 1'b0;
        end else if ((r_state == S_DECODE) && (w_next == S_TRAP)) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign illegal_op = r_illegal_op;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
module tb_riscv_mc_controller;

  localparam logic [3:0] ST_F   = 4'd0;
  localparam logic [3:0] ST_D   = 4'd1;
  localparam logic [3:0] ST_MA  = 4'd2;
  localparam logic [3:0] ST_MR  = 4'd3;
  localparam logic [3:0] ST_MWB = 4'd4;
  localparam logic [3:0] ST_MWR = 4'd5;
  localparam logic [3:0] ST_ER  = 4'd6;
  localparam logic [3:0] ST_EI  = 4'd7;
  localparam logic [3:0] ST_AW  = 4'd8;
  localparam logic [3:0] ST_BEQ = 4'd9;
  localparam logic [3:0] ST_JAL = 4'd10;
  localparam logic [3:0] ST_TRP = 4'd11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  // DUT with no memory wait
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  // DUT with two wait cycles per memory access
  logic       pc_write_w, adr_src_w, mem_write_w, ir_write_w, reg_write_w, illegal_op_w;
  logic [1:0] result_src_w, alu_src_a_w, alu_src_b_w, imm_src_w;
  logic [2:0] alu_control_w;
  logic [3:0] state_o_w;

  riscv_mc_controller #(.MEM_WAIT_CYCLES(0), .STATE_W(4)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .imm_src(imm_src),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  riscv_mc_controller #(.MEM_WAIT_CYCLES(2), .STATE_W(4)) u_dut_w (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write_w), .adr_src(adr_src_w), .mem_write(mem_write_w), .ir_write(ir_write_w),
    .reg_write(reg_write_w), .result_src(result_src_w), .alu_src_a(alu_src_a_w),
    .alu_src_b(alu_src_b_w), .alu_control(alu_control_w), .imm_src(imm_src_w),
    .illegal_op(illegal_op_w), .state_o(state_o_w)
  );

  // Packed view of every controller output, compared as one word per cycle.
  logic [21:0] act_word;
  assign act_word = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                     alu_src_a, alu_src_b, alu_control, imm_src, state_o};

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pop(input string name, input int cyc);
    logic [21:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s cyc%0d: got %h expected <empty queue>", name, cyc, act_word);
    end else begin
      e = exp_q.pop_front();
      if (act_word !== e) begin
        n_errors++;
        $display("FAIL %s cyc%0d: got %h expected %h", name, cyc, act_word, e);
      end
    end
  endtask

  // Reference of the control word for a given state and instruction fields.
  function automatic logic [21:0] exp_ctrl(input logic [3:0] st, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7, input logic z);
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu, alu_f;
    pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    if (o == 7'b0100011)      imm = 2'b01;
    else if (o == 7'b1100011) imm = 2'b10;
    else if (o == 7'b1101111) imm = 2'b11;
    else                      imm = 2'b00;
    if (f3 == 3'b000)      alu_f = (f7 && o[5]) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) alu_f = 3'b101;
    else if (f3 == 3'b110) alu_f = 3'b011;
    else if (f3 == 3'b111) alu_f = 3'b010;
    else                   alu_f = 3'b000;
    case (st)
      ST_F:   begin sb = 2'b10; res = 2'b10; irw = 1; pcw = 1; end
      ST_D:   begin sa = 2'b01; sb = 2'b01; end
      ST_MA:  begin sa = 2'b10; sb = 2'b01; end
      ST_MR:  begin adr = 1; end
      ST_MWB: begin res = 2'b01; regw = 1; end
      ST_MWR: begin adr = 1; memw = 1; end
      ST_ER:  begin sa = 2'b10; alu = alu_f; end
      ST_EI:  begin sa = 2'b10; sb = 2'b01; alu = alu_f; end
      ST_AW:  begin regw = 1; end
      ST_BEQ: begin sa = 2'b10; alu = 3'b001; pcw = z; end
      ST_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, memw, irw, regw, res, sa, sb, alu, imm, st};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         n;
    logic [3:0] seq [5];
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string nm, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input int n,
                                  input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                                  input logic [3:0] s3, input logic [3:0] s4);
    vec_t v;
    v.name = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1.
  task automatic run_vec(input vec_t v);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
    for (int k = 0; k < v.n; k++) begin
      exp_q.push_back(exp_ctrl(v.seq[k], v.op, v.f3, v.f7, v.z));
      @(negedge clk);
      check_pop(v.name, k);
      @(posedge clk);
      #1;
    end
  endtask

  // Expected {state, ir_write, pc_write, mem_write, adr_src} of the wait DUT for sw.
  logic [7:0] wait_exp [9];
  vec_t       v_ill;

  initial begin
    reset = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;

    add_vec("lw",      7'b0000011, 3'b010, 0, 0, 5, ST_F, ST_D, ST_MA, ST_MR, ST_MWB);
    add_vec("sw",      7'b0100011, 3'b010, 0, 0, 4, ST_F, ST_D, ST_MA, ST_MWR, ST_F);
    add_vec("add",     7'b0110011, 3'b000, 0, 0, 4, ST_F, ST_D, ST_ER, ST_AW, ST_F);
    add_vec("sub",     7'b0110011, 3'b000, 1, 0, 4, ST_F, ST_D, ST_ER, ST_AW, ST_F);
    add_vec("and",     7'b0110011, 3'b111, 0, 1, 4, ST_F, ST_D, ST_ER, ST_AW, ST_F);
    add_vec("slt",     7'b0110011, 3'b010, 0, 0, 4, ST_F, ST_D, ST_ER, ST_AW, ST_F);
    add_vec("or",      7'b0110011, 3'b110, 1, 0, 4, ST_F, ST_D, ST_ER, ST_AW, ST_F);
    add_vec("addi_f7", 7'b0010011, 3'b000, 1, 0, 4, ST_F, ST_D, ST_EI, ST_AW, ST_F);
    add_vec("xori",    7'b0010011, 3'b100, 0, 0, 4, ST_F, ST_D, ST_EI, ST_AW, ST_F);
    add_vec("andi",    7'b0010011, 3'b111, 0, 0, 4, ST_F, ST_D, ST_EI, ST_AW, ST_F);
    add_vec("beq_t",   7'b1100011, 3'b000, 0, 1, 3, ST_F, ST_D, ST_BEQ, ST_F, ST_F);
    add_vec("beq_nt",  7'b1100011, 3'b000, 0, 0, 3, ST_F, ST_D, ST_BEQ, ST_F, ST_F);
    add_vec("jal",     7'b1101111, 3'b000, 0, 0, 4, ST_F, ST_D, ST_JAL, ST_AW, ST_F);

    // ---- reset held for 3 cycles ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
    check("rst_state", {28'd0, state_o}, 32'd0);
    check("rst_fetch_srcs", {28'd0, alu_src_b, result_src}, {28'd0, 4'b1010});
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    check("rst_enables_w", {28'd0, pc_write_w, ir_write_w, reg_write_w, mem_write_w}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rel_fetch", {29'd0, ir_write, pc_write, alu_src_b[1]}, 32'd7);

    // ---- table-driven instruction sequences ----
    foreach (vecs[i]) run_vec(vecs[i]);

    // ---- reset in the middle of lw aborts it ----
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_pre_state", {28'd0, state_o}, {28'd0, ST_MR});
    reset = 1'b0;
    #1;
    check("abort_state", {28'd0, state_o}, 32'd0);
    check("abort_enables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_held", {24'd0, state_o, pc_write, ir_write, reg_write, mem_write}, 32'd0);

    // ---- two wait cycles: sw on the stretched DUT ----
    wait_exp[0] = {ST_F, 4'b0000};
    wait_exp[1] = {ST_F, 4'b0000};
    wait_exp[2] = {ST_F, 4'b1100};
    wait_exp[3] = {ST_D, 4'b0000};
    wait_exp[4] = {ST_MA, 4'b0000};
    wait_exp[5] = {ST_MWR, 4'b0001};
    wait_exp[6] = {ST_MWR, 4'b0001};
    wait_exp[7] = {ST_MWR, 4'b0011};
    wait_exp[8] = {ST_F, 4'b0000};
    op = 7'b0100011; funct3 = 3'b010;
    reset = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("wait_sw cyc%0d", k),
            {24'd0, state_o_w, ir_write_w, pc_write_w, mem_write_w, adr_src_w},
            {24'd0, wait_exp[k]});
      @(posedge clk);
      #1;
    end

    // ---- illegal opcode ----
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    v_ill.name = "illegal"; v_ill.op = 7'b0000000; v_ill.f3 = 3'b000; v_ill.f7 = 1'b0;
    v_ill.z = 1'b0; v_ill.n = 4;
    v_ill.seq[0] = ST_F; v_ill.seq[1] = ST_D; v_ill.seq[4] = ST_F;
`ifdef RISCV_MC_TRAP_EN
    v_ill.seq[2] = ST_TRP; v_ill.seq[3] = ST_TRP;
`else
    v_ill.seq[2] = ST_F; v_ill.seq[3] = ST_D;
`endif
    run_vec(v_ill);
`ifdef RISCV_MC_TRAP_EN
    check("illegal_flag", {31'd0, illegal_op}, 32'd1);
    reset = 1'b0;
    #1;
    check("illegal_cleared", {27'd0, illegal_op, state_o}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
`else
    check("illegal_flag", {31'd0, illegal_op}, 32'd0);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
